fixed_pair_stream: RTL and testbench

FIXED_PAIR_STREAM -- requirements
Module: fixed_pair_stream

---
 rtl/fixed_pkg.sv | 14 +
 rtl/fixed_sync_fifo.sv | 55 +++++
 rtl/fixed_pair_stream.sv | 133 +++++++++++++
 tb/tb_fixed_pair_stream.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_pkg.sv
// Shared types for the fixed-point pair streamer: FSM state encoding and
// the FIFO pointer-width helper.
package fixed_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fixed_sync_fifo.sv
// Single-clock FIFO with a combinational head so a word pushed into an empty
// FIFO is visible on the very next cycle. DEPTH must be a power of two.
module fixed_sync_fifo
  import fixed_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (PW+1)'(1);
        2'b01:   count_reg <= count_reg - (PW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/fixed_pair_stream.sv
// Pairs two fixed-point operand streams into lock-step A/B egress with vector
// framing (last, len_err). Optional FIXED_PAIR_STREAM_STATS_EN adds vec_done_cnt.
module fixed_pair_stream
  import fixed_pkg::*;
#(
  parameter int WI1   = 4,
  parameter int WF1   = 8,
  parameter int WI2   = 3,
  parameter int WF2   = 5,
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WI1+WF1-1:0] a_in_data,
  input  logic               a_in_valid,
  output logic               a_in_ready,
  input  logic [WI2+WF2-1:0] b_in_data,
  input  logic               b_in_valid,
  output logic               b_in_ready,
  input  logic [LEN_W-1:0]   vec_len,
  output logic [WI1+WF1-1:0] A_data,
  output logic               A_valid,
  output logic               A_last,
  input  logic               A_ready,
  output logic [WI2+WF2-1:0] B_data,
  output logic               B_valid,
  output logic               B_last,
  input  logic               B_ready,
  output logic               len_err
`ifdef FIXED_PAIR_STREAM_STATS_EN
  ,
  output logic [15:0]        vec_done_cnt
`endif
);

  localparam int AW = WI1 + WF1;
  localparam int BW = WI2 + WF2;

  logic [AW-1:0]    a_head;
  logic [BW-1:0]    b_head;
  logic             a_empty, a_full, b_empty, b_full;
  logic             pair_valid, fire, last;
  state_t           state_reg, state_next;
  logic [LEN_W-1:0] count_reg, count_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] len_eff, count_eff;
  logic             start, len_zero;
  logic             len_err_reg;

  assign a_in_ready = !a_full && !reset;
  assign b_in_ready = !b_full && !reset;
  assign pair_valid = !a_empty && !b_empty;
  assign fire       = pair_valid && A_ready && B_ready;

  fixed_sync_fifo #(.WIDTH(AW), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .reset     (reset),
    .push      (a_in_valid && a_in_ready),
    .push_data (a_in_data),
    .pop       (fire),
    .head      (a_head),
    .empty     (a_empty),
    .full      (a_full)
  );

  fixed_sync_fifo #(.WIDTH(BW), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .reset     (reset),
    .push      (b_in_valid && b_in_ready),
    .push_data (b_in_data),
    .pop       (fire),
    .head      (b_head),
    .empty     (b_empty),
    .full      (b_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      len_reg     <= '0;
      len_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      len_reg     <= len_next;
      len_err_reg <= fire && start && len_zero;
    end
  end

  // In IDLE the head pair opens a vector, so framing uses the live vec_len.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    len_next   = len_reg;
    start      = (state_reg == IDLE);
    len_zero   = (vec_len == '0);
    len_eff    = start ? (len_zero ? LEN_W'(1) : vec_len) : len_reg;
    count_eff  = start ? '0 : count_reg;
    last       = pair_valid && (count_eff == len_eff - LEN_W'(1));
    if (fire) begin
      if (start) len_next = len_eff;
      if (last) begin
        state_next = IDLE;
        count_next = '0;
      end else begin
        state_next = STREAM;
        count_next = count_eff + LEN_W'(1);
      end
    end
  end

  assign A_valid = pair_valid && !reset;
  assign B_valid = pair_valid && !reset;
  assign A_last  = last && !reset;
  assign B_last  = last && !reset;
  assign A_data  = reset ? '0 : a_head;
  assign B_data  = reset ? '0 : b_head;
  assign len_err = len_err_reg;

`ifdef FIXED_PAIR_STREAM_STATS_EN
  logic [15:0] vec_done_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             vec_done_reg <= '0;
    else if (fire && last) vec_done_reg <= vec_done_reg + 16'd1;
  end

  assign vec_done_cnt = vec_done_reg;
`endif

endmodule

// File: tb/tb_fixed_pair_stream.sv
// Directed table-driven bench for fixed_pair_stream with hand-written stall,
// reset and statistics sequences.
module tb_fixed_pair_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] a_in_data;
  logic        a_in_valid, a_in_ready;
  logic [7:0]  b_in_data;
  logic        b_in_valid, b_in_ready;
  logic [7:0]  vec_len;
  logic [11:0] A_data;
  logic        A_valid, A_last, A_ready;
  logic [7:0]  B_data;
  logic        B_valid, B_last, B_ready;
  logic        len_err;
`ifdef FIXED_PAIR_STREAM_STATS_EN
  logic [15:0] vec_done_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_pair_stream dut (
    .clk          (clk),
    .reset        (reset),
    .a_in_data    (a_in_data),
    .a_in_valid   (a_in_valid),
    .a_in_ready   (a_in_ready),
    .b_in_data    (b_in_data),
    .b_in_valid   (b_in_valid),
    .b_in_ready   (b_in_ready),
    .vec_len      (vec_len),
    .A_data       (A_data),
    .A_valid      (A_valid),
    .A_last       (A_last),
    .A_ready      (A_ready),
    .B_data       (B_data),
    .B_valid      (B_valid),
    .B_last       (B_last),
    .B_ready      (B_ready),
    .len_err      (len_err)
`ifdef FIXED_PAIR_STREAM_STATS_EN
    ,
    .vec_done_cnt (vec_done_cnt)
`endif
  );

  typedef struct {
    logic        av;
    logic [11:0] ad;
    logic        bv;
    logic [7:0]  bd;
    logic        rdy;
    logic [7:0]  len;
    logic        ev;
    logic [11:0] ea;
    logic [7:0]  eb;
    logic        el;
    logic        ear;
    logic        ebr;
    logic        ele;
  } vec_t;

  vec_t tbl [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [11:0] ad, input logic bv,
                       input logic [7:0] bd, input logic rdy, input logic [7:0] len);
    a_in_valid = av; a_in_data = ad;
    b_in_valid = bv; b_in_data = bd;
    A_ready = rdy; B_ready = rdy;
    vec_len = len;
  endtask

  // Checks the paired egress; data compared only when a pair is expected.
  task automatic check_pair(input string tag, input logic ev, input logic [11:0] ea,
                            input logic [7:0] eb, input logic el);
    check({tag, " A_valid"}, 32'(A_valid), 32'(ev));
    check({tag, " B_valid"}, 32'(B_valid), 32'(ev));
    check({tag, " A_last"},  32'(A_last),  32'(el));
    check({tag, " B_last"},  32'(B_last),  32'(el));
    if (ev) begin
      check({tag, " A_data"}, 32'(A_data), 32'(ea));
      check({tag, " B_data"}, 32'(B_data), 32'(eb));
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    // av  ad       bv  bd     rdy  len    ev  ea       eb     el  ear ebr ele
    tbl[0]  = '{1'b1, 12'h100, 1'b1, 8'h20, 1'b1, 8'd4, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 12'h200, 1'b1, 8'h20, 1'b1, 8'd4, 1'b1, 12'h100, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 12'h300, 1'b1, 8'h20, 1'b1, 8'd4, 1'b1, 12'h200, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 12'h400, 1'b1, 8'h20, 1'b1, 8'd4, 1'b1, 12'h300, 8'h20, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd4, 1'b1, 12'h400, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd4, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    // zero-length vector
    tbl[6]  = '{1'b1, 12'h180, 1'b1, 8'h10, 1'b1, 8'd0, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd0, 1'b1, 12'h180, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd4, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    // A runs ahead of B, vec_len=2
    tbl[10] = '{1'b1, 12'h010, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b1, 12'h020, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 12'h030, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 12'h040, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 12'h050, 1'b1, 8'h01, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b1, 12'h050, 1'b1, 8'h02, 1'b1, 8'd2, 1'b1, 12'h010, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b1, 12'h050, 1'b1, 8'h03, 1'b1, 8'd2, 1'b1, 12'h020, 8'h02, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 12'h000, 1'b1, 8'h04, 1'b1, 8'd2, 1'b1, 12'h030, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd2, 1'b1, 12'h040, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 12'h000, 1'b1, 8'h05, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd2, 1'b1, 12'h050, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 12'h000, 1'b0, 8'h00, 1'b1, 8'd2, 1'b0, 12'h000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};

    reset = 1'b1;
    drive(1'b0, 12'h0, 1'b0, 8'h0, 1'b0, 8'd0);
    @(negedge clk);
    #1;
    check("reset A_valid", 32'(A_valid), 32'd0);
    check("reset B_valid", 32'(B_valid), 32'd0);
    check("reset a_in_ready", 32'(a_in_ready), 32'd0);
    check("reset b_in_ready", 32'(b_in_ready), 32'd0);
    check("reset A_data", 32'(A_data), 32'd0);
    check("reset len_err", 32'(len_err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].rdy, tbl[i].len);
      #1;
      check_pair($sformatf("row%0d", i), tbl[i].ev, tbl[i].ea, tbl[i].eb, tbl[i].el);
      check($sformatf("row%0d a_in_ready", i), 32'(a_in_ready), 32'(tbl[i].ear));
      check($sformatf("row%0d b_in_ready", i), 32'(b_in_ready), 32'(tbl[i].ebr));
      check($sformatf("row%0d len_err", i), 32'(len_err), 32'(tbl[i].ele));
      $display("row %0d: A_valid=%0b A_data=%h B_data=%h last=%0b len_err=%0b",
               i, A_valid, A_data, B_data, A_last, len_err);
      next_cycle();
    end

    // Stall: the vector left open above has len_q=2, count=1, so this pair is
    // its last even though the live vec_len now reads 7.
    drive(1'b1, 12'hABC, 1'b1, 8'h9D, 1'b0, 8'd7);
    #1;
    check_pair("stall pre", 1'b0, 12'h0, 8'h0, 1'b0);
    next_cycle();
    drive(1'b0, 12'h0, 1'b0, 8'h0, 1'b0, 8'd7);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_pair($sformatf("stall%0d", i), 1'b1, 12'hABC, 8'h9D, 1'b1);
      $display("stall %0d: A_valid=%0b A_data=%h last=%0b", i, A_valid, A_data, A_last);
      next_cycle();
    end
    A_ready = 1'b1; B_ready = 1'b1;
    #1;
    check_pair("stall release", 1'b1, 12'hABC, 8'h9D, 1'b1);
    next_cycle();
    #1;
    check_pair("stall drained", 1'b0, 12'h0, 8'h0, 1'b0);

    // Mid-vector reset: two pairs of a 6-pair vector fire, the third is queued.
    drive(1'b1, 12'h111, 1'b1, 8'h11, 1'b1, 8'd6);
    next_cycle();
    drive(1'b1, 12'h222, 1'b1, 8'h22, 1'b1, 8'd6);
    #1;
    check_pair("rst p1", 1'b1, 12'h111, 8'h11, 1'b0);
    next_cycle();
    drive(1'b1, 12'h333, 1'b1, 8'h33, 1'b1, 8'd6);
    #1;
    check_pair("rst p2", 1'b1, 12'h222, 8'h22, 1'b0);
    next_cycle();
    reset = 1'b1;
    drive(1'b0, 12'h0, 1'b0, 8'h0, 1'b1, 8'd3);
    #1;
    check("midrst A_valid", 32'(A_valid), 32'd0);
    check("midrst A_last", 32'(A_last), 32'd0);
    check("midrst a_in_ready", 32'(a_in_ready), 32'd0);
    check("midrst b_in_ready", 32'(b_in_ready), 32'd0);
    check("midrst A_data", 32'(A_data), 32'd0);
    check("midrst B_data", 32'(B_data), 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    check_pair("post rst", 1'b0, 12'h0, 8'h0, 1'b0);
    check("post rst a_in_ready", 32'(a_in_ready), 32'd1);
    drive(1'b1, 12'hF00, 1'b1, 8'hE0, 1'b1, 8'd3);
    next_cycle();
    drive(1'b1, 12'hF80, 1'b1, 8'hF0, 1'b1, 8'd3);
    #1;
    check_pair("new q1", 1'b1, 12'hF00, 8'hE0, 1'b0);
    next_cycle();
    drive(1'b1, 12'h080, 1'b1, 8'h10, 1'b1, 8'd3);
    #1;
    check_pair("new q2", 1'b1, 12'hF80, 8'hF0, 1'b0);
    next_cycle();
    drive(1'b0, 12'h0, 1'b0, 8'h0, 1'b1, 8'd3);
    #1;
    check_pair("new q3", 1'b1, 12'h080, 8'h10, 1'b1);
    $display("reset seq: q3 A_data=%h last=%0b", A_data, A_last);
    next_cycle();
    #1;
    check_pair("new drained", 1'b0, 12'h0, 8'h0, 1'b0);

`ifdef FIXED_PAIR_STREAM_STATS_EN
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1;
    check("stats reset", 32'(vec_done_cnt), 32'd0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 12'(i + 1), 1'b1, 8'(i + 1), 1'b1, 8'd2);
      next_cycle();
    end
    drive(1'b0, 12'h0, 1'b0, 8'h0, 1'b1, 8'd2);
    next_cycle();
    next_cycle();
    #1;
    check("stats vec_done_cnt", 32'(vec_done_cnt), 32'd3);
    $display("stats: vec_done_cnt=%0d", vec_done_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
